// File: rtl/rf_writeback_arb_if.sv
// Write-back bus between the ALU/load sources, the arbiter and the register file.
interface rf_writeback_arb_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [CNT_W-1:0]  buf_count;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    input  ld_ready, wr_en, wr_addr, wr_data, buf_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
    output ld_ready, wr_en, wr_addr, wr_data, buf_count
  );
endinterface

// File: rtl/rf_writeback_arb.sv
// Register-file write-back arbiter: ALU has priority, colliding loads queue in a squashable FIFO.
// Optional performance counters are enabled by defining RF_WB_PERF_EN.
module rf_writeback_arb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst,
  rf_writeback_arb_if.slave   wb
`ifdef RF_WB_PERF_EN
  ,
  output logic [15:0]         perf_stall,
  output logic [15:0]         perf_squash
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr_reg [DEPTH];
  logic [DATA_W-1:0] mem_data_reg [DEPTH];
  logic [DEPTH-1:0]  vld_reg, vld_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              wr_en_reg, wr_en_next;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic [DATA_W-1:0] wr_data_reg, wr_data_next;

  logic             ld_acc, fifo_empty, push, pop, push_vld, same_squash;
  logic [DEPTH-1:0] match;

  assign wb.ld_ready  = (count_reg != CNT_W'(DEPTH));
  assign ld_acc       = wb.ld_valid && wb.ld_ready;
  assign fifo_empty   = (count_reg == '0);
  assign same_squash  = wb.alu_valid && ld_acc && (wb.ld_addr == wb.alu_addr);

  // Live entries that an ALU write to the same register makes stale.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = vld_reg[gi] && (mem_addr_reg[gi] == wb.alu_addr);
    end
  endgenerate

  always_comb begin
    push         = 1'b0;
    pop          = 1'b0;
    push_vld     = 1'b1;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;
    wr_data_next = wr_data_reg;
    vld_next     = vld_reg;
    if (wb.alu_valid) begin
      wr_en_next   = 1'b1;
      wr_addr_next = wb.alu_addr;
      wr_data_next = wb.alu_data;
      push         = ld_acc;
      push_vld     = !same_squash;
      vld_next     = vld_reg & ~match;
    end else if (!fifo_empty) begin
      pop  = 1'b1;
      push = ld_acc;
      // A squashed head is retired silently; the write port keeps its last values.
      if (vld_reg[rd_ptr_reg]) begin
        wr_en_next   = 1'b1;
        wr_addr_next = mem_addr_reg[rd_ptr_reg];
        wr_data_next = mem_data_reg[rd_ptr_reg];
      end
    end else if (ld_acc) begin
      wr_en_next   = 1'b1;
      wr_addr_next = wb.ld_addr;
      wr_data_next = wb.ld_data;
    end
    if (pop)  vld_next[rd_ptr_reg] = 1'b0;
    if (push) vld_next[wr_ptr_reg] = push_vld;
    rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
    wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
    count_next  = count_reg;
    if (push && !pop)      count_next = count_reg + 1'b1;
    else if (pop && !push) count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_reg     <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
    end else begin
      vld_reg     <= vld_next;
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
    end
  end

  // Payload storage needs no reset; the valid bits and count qualify it.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_addr_reg[wr_ptr_reg] <= wb.ld_addr;
      mem_data_reg[wr_ptr_reg] <= wb.ld_data;
    end
  end

  assign wb.wr_en     = wr_en_reg;
  assign wb.wr_addr   = wr_addr_reg;
  assign wb.wr_data   = wr_data_reg;
  assign wb.buf_count = count_reg;

`ifdef RF_WB_PERF_EN
  logic [15:0] squash_inc;
  logic [16:0] stall_sum, squash_sum;

  always_comb begin
    squash_inc = {15'd0, same_squash};
    if (wb.alu_valid) begin
      for (int i = 0; i < DEPTH; i++) squash_inc = squash_inc + {15'd0, match[i]};
    end
  end

  assign stall_sum  = {1'b0, perf_stall} + {16'd0, wb.ld_valid && !wb.ld_ready};
  assign squash_sum = {1'b0, perf_squash} + {1'b0, squash_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_squash <= '0;
    end else begin
      perf_stall  <= stall_sum[16]  ? 16'hFFFF : stall_sum[15:0];
      perf_squash <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_rf_writeback_arb.sv
// Directed bench for rf_writeback_arb with hand-computed expected write-port values.
`timescale 1ns/1ps
module tb_rf_writeback_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rf_writeback_arb_if #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) wb ();

`ifdef RF_WB_PERF_EN
  logic [15:0] perf_stall, perf_squash;
`endif

  rf_writeback_arb #(.DATA_W(16), .ADDR_W(3), .DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .wb(wb)
`ifdef RF_WB_PERF_EN
    ,
    .perf_stall(perf_stall),
    .perf_squash(perf_squash)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic lv, input logic [2:0] la, input logic [15:0] ldd);
    wb.alu_valid = av; wb.alu_addr = aa; wb.alu_data = ad;
    wb.ld_valid  = lv; wb.ld_addr  = la; wb.ld_data  = ldd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction: check the write port and buffer state seen after an edge.
  task automatic expect_wr(input string tag, input logic en, input logic [2:0] a,
                           input logic [15:0] d, input int cnt);
    chk({tag, ".en"}, {31'd0, wb.wr_en}, {31'd0, en});
    if (en) begin
      chk({tag, ".addr"}, {29'd0, wb.wr_addr}, {29'd0, a});
      chk({tag, ".data"}, {16'd0, wb.wr_data}, {16'd0, d});
    end
    chk({tag, ".cnt"}, {30'd0, wb.buf_count}, cnt);
    $display("txn %-12s en=%0b addr=%0d data=%h cnt=%0d rdy=%0b", tag, wb.wr_en, wb.wr_addr,
             wb.wr_data, wb.buf_count, wb.ld_ready);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst.en", {31'd0, wb.wr_en}, 0);
    chk("rst.addr", {29'd0, wb.wr_addr}, 0);
    chk("rst.data", {16'd0, wb.wr_data}, 0);
    chk("rst.cnt", {30'd0, wb.buf_count}, 0);
    chk("rst.rdy", {31'd0, wb.ld_ready}, 1);
    step();
    expect_wr("idle", 0, 0, 0, 0);

    // Lone load bypasses the empty FIFO; the port then holds its values.
    drive(0, 0, 0, 1, 5, 16'hBEEF); step(); expect_wr("byp", 1, 5, 16'hBEEF, 0);
    drive(0, 0, 0, 0, 0, 0); step();
    expect_wr("byp.hold", 0, 0, 0, 0);
    chk("byp.hold.addr", {29'd0, wb.wr_addr}, 5);
    chk("byp.hold.data", {16'd0, wb.wr_data}, 16'hBEEF);

    // Collision and drain.
    drive(1, 2, 16'h1111, 1, 3, 16'h2222); step(); expect_wr("col0", 1, 2, 16'h1111, 1);
    chk("col0.rdy", {31'd0, wb.ld_ready}, 1);
    drive(1, 4, 16'h3333, 1, 6, 16'h4444); step(); expect_wr("col1", 1, 4, 16'h3333, 2);
    chk("col1.rdy", {31'd0, wb.ld_ready}, 0);
    drive(0, 0, 0, 0, 0, 0); step(); expect_wr("col2", 1, 3, 16'h2222, 1);
    step(); expect_wr("col3", 1, 6, 16'h4444, 0);
    step(); expect_wr("col4", 0, 0, 0, 0);

    // Back-pressure: the source holds (7,5555) until a slot frees.
    drive(1, 0, 16'h0A01, 1, 1, 16'h0B01); step(); expect_wr("bp0", 1, 0, 16'h0A01, 1);
    drive(1, 2, 16'h0A02, 1, 3, 16'h0B02); step(); expect_wr("bp1", 1, 2, 16'h0A02, 2);
    chk("bp1.rdy", {31'd0, wb.ld_ready}, 0);
    drive(1, 4, 16'h0A03, 1, 7, 16'h5555); step(); expect_wr("bp2", 1, 4, 16'h0A03, 2);
    drive(1, 5, 16'h0A04, 1, 7, 16'h5555); step(); expect_wr("bp3", 1, 5, 16'h0A04, 2);
    drive(0, 0, 0, 1, 7, 16'h5555); step(); expect_wr("bp4", 1, 1, 16'h0B01, 1);
    chk("bp4.rdy", {31'd0, wb.ld_ready}, 1);
    step(); expect_wr("bp5", 1, 3, 16'h0B02, 1);
    drive(0, 0, 0, 0, 0, 0); step(); expect_wr("bp6", 1, 7, 16'h5555, 0);
    step(); expect_wr("bp7", 0, 0, 0, 0);
`ifdef RF_WB_PERF_EN
    chk("perf_stall", {16'd0, perf_stall}, 3);
`endif

    // Squash of a buffered entry, then of a same-cycle load.
    drive(1, 3, 16'h0303, 1, 1, 16'hAAAA); step(); expect_wr("sq0", 1, 3, 16'h0303, 1);
    drive(1, 1, 16'hCCCC, 0, 0, 0); step(); expect_wr("sq1", 1, 1, 16'hCCCC, 1);
    drive(0, 0, 0, 0, 0, 0); step(); expect_wr("sq2", 0, 0, 0, 0);
    chk("sq2.addr", {29'd0, wb.wr_addr}, 1);
    chk("sq2.data", {16'd0, wb.wr_data}, 16'hCCCC);
`ifdef RF_WB_PERF_EN
    chk("perf_squash1", {16'd0, perf_squash}, 1);
`endif
    drive(1, 6, 16'h6666, 1, 6, 16'h7777); step(); expect_wr("sq3", 1, 6, 16'h6666, 1);
    drive(0, 0, 0, 0, 0, 0); step(); expect_wr("sq4", 0, 0, 0, 0);
    chk("sq4.data", {16'd0, wb.wr_data}, 16'h6666);
`ifdef RF_WB_PERF_EN
    chk("perf_squash2", {16'd0, perf_squash}, 2);
`endif

    // Register 0 through the bypass path.
    drive(0, 0, 0, 1, 0, 16'h0F0F); step(); expect_wr("r0", 1, 0, 16'h0F0F, 0);

    // Reset mid-drain discards both buffered loads and a load offered during reset.
    drive(1, 2, 16'h1212, 1, 4, 16'h4444); step(); expect_wr("rm0", 1, 2, 16'h1212, 1);
    drive(1, 3, 16'h1313, 1, 5, 16'h5555); step(); expect_wr("rm1", 1, 3, 16'h1313, 2);
    drive(0, 0, 0, 1, 6, 16'h6666);
    rst = 1'b1; step(); expect_wr("rm2", 0, 0, 0, 0);
    chk("rm2.rdy", {31'd0, wb.ld_ready}, 1);
    chk("rm2.addr", {29'd0, wb.wr_addr}, 0);
    rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    step(); expect_wr("rm3", 0, 0, 0, 0);
    step(); expect_wr("rm4", 0, 0, 0, 0);
`ifdef RF_WB_PERF_EN
    chk("perf_rst", {perf_stall, perf_squash}, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
